// File: rtl/uart_rx_ahb_fifo.sv
// AHB-Lite MMIO slave that buffers UART receive bytes in a FIFO and raises an
// interrupt when the fill level reaches a programmable threshold or bytes were lost.
module uart_rx_ahb_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESH_RST = 1
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         threshold;
  logic [CW-1:0]         thresh_eff;
  logic                  overflow;
  logic                  irq_en;
  logic                  wr_pending;
  logic [1:0]            wr_sel;

  logic        rd_req;
  logic        wr_req;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        flush;
  logic        ovf_set;
  logic        ovf_clr;
  logic        ctrl_wr;
  logic [31:0] status_word;
  logic [31:0] ctrl_word;
  logic [31:0] rd_word;
  logic        unused_inputs;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;

  assign unused_inputs = ^{HSIZE, HADDR[1:0], HTRANS[0], HWDATA};

  assign rd_req = HSEL & HTRANS[1] & HREADY & ~HWRITE;
  assign wr_req = HSEL & HTRANS[1] & HREADY & HWRITE;
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop    = rd_req & (HADDR[3:2] == REG_DATA) & ~empty;

  // Data-phase write effects; a pop frees a slot so a push at full still lands.
  assign ctrl_wr = wr_pending & (wr_sel == REG_CTRL);
  assign flush   = wr_pending & (wr_sel == REG_CLEAR) & HWDATA[1];
  assign ovf_clr = wr_pending & (wr_sel == REG_CLEAR) & HWDATA[0];
  assign push    = RX_VALID & (~full | pop) & ~flush;
  assign ovf_set = RX_VALID & full & ~pop;

  assign thresh_eff = (threshold == '0) ? CW'(1) : threshold;

  always_comb begin
    status_word          = '0;
    status_word[8 +: CW] = count;
    status_word[2]       = overflow;
    status_word[1]       = full;
    status_word[0]       = ~empty;
  end

  always_comb begin
    ctrl_word          = '0;
    ctrl_word[8 +: CW] = threshold;
    ctrl_word[0]       = irq_en;
  end

  always_comb begin
    rd_word = '0;
    case (HADDR[3:2])
      REG_DATA:   rd_word = empty ? 32'h0 : {23'b0, 1'b1, mem[rd_ptr]};
      REG_STATUS: rd_word = status_word;
      REG_CTRL:   rd_word = ctrl_word;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= RX_DATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A lost byte in the same cycle as a software clear keeps the flag set.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      wr_pending <= 1'b0;
      wr_sel     <= 2'b00;
      irq_en     <= 1'b0;
      threshold  <= CW'(THRESH_RST);
    end else begin
      wr_pending <= wr_req;
      wr_sel     <= HADDR[3:2];
      if (ctrl_wr) begin
        irq_en    <= HWDATA[0];
        threshold <= HWDATA[8 +: CW];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      HRDATA <= '0;
      IRQ    <= 1'b0;
    end else begin
      if (rd_req) begin
        HRDATA <= rd_word;
      end
      IRQ <= irq_en & ((count >= thresh_eff) | overflow);
    end
  end

endmodule

// File: tb/tb_uart_rx_ahb_fifo.sv
// Randomized bench for uart_rx_ahb_fifo: a queue-based model of the receive FIFO
// and its registers predicts every read and the interrupt line cycle by cycle.
module tb_uart_rx_ahb_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        HSEL;
  logic [3:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        IRQ;

  always #5 HCLK = ~HCLK;

  uart_rx_ahb_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .THRESH_RST(1)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .IRQ(IRQ)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  fifo_q[$];
  bit          model_ovf;
  bit          model_irq_en;
  logic [4:0]  model_thr;
  bit          pend_wr;
  logic [1:0]  pend_reg;
  logic [31:0] pend_data;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = fifo_q.size();
    return (32'(n) << 8) | (32'(model_ovf) << 2) | (32'(n == DEPTH) << 1) | 32'(n != 0);
  endfunction

  function automatic bit model_irq();
    int thr;
    thr = (model_thr == 0) ? 1 : int'(model_thr);
    return model_irq_en && ((fifo_q.size() >= thr) || model_ovf);
  endfunction

  // One bus/UART cycle: address phase of an optional transfer, data phase of the previous write.
  task automatic applyStimulus(input bit rx_v, input logic [7:0] rx_d, input bit bus_rd,
                               input bit bus_wr, input logic [1:0] sel, input logic [31:0] wdata);
    logic [31:0] exp_rd;
    bit irq_exp, was_full, do_pop, flush, ovf_clr;
    RX_VALID = rx_v;
    RX_DATA  = rx_d;
    HSEL     = bus_rd | bus_wr;
    HTRANS   = (bus_rd | bus_wr) ? 2'b10 : 2'b00;
    HWRITE   = bus_wr;
    HADDR    = {sel, 2'b00};
    HSIZE    = 3'b010;
    HREADY   = 1'b1;
    HWDATA   = pend_wr ? pend_data : $urandom;

    irq_exp  = model_irq();
    was_full = (fifo_q.size() == DEPTH);
    do_pop   = bus_rd && (sel == 2'd0) && (fifo_q.size() != 0);
    if (sel == 2'd0)      exp_rd = do_pop ? {23'b0, 1'b1, fifo_q[0]} : 32'h0;
    else if (sel == 2'd1) exp_rd = model_status();
    else if (sel == 2'd2) exp_rd = {19'b0, model_thr, 7'b0, model_irq_en};
    else                  exp_rd = 32'h0;
    flush   = pend_wr && (pend_reg == 2'd3) && pend_data[1];
    ovf_clr = pend_wr && (pend_reg == 2'd3) && pend_data[0];

    @(posedge HCLK);
    #1;
    if (do_pop) void'(fifo_q.pop_front());
    if (flush) fifo_q.delete();
    else if (rx_v && !(was_full && !do_pop)) fifo_q.push_back(rx_d);
    if (rx_v && was_full && !do_pop) model_ovf = 1'b1;
    else if (ovf_clr) model_ovf = 1'b0;
    if (pend_wr && pend_reg == 2'd2) begin
      model_irq_en = pend_data[0];
      model_thr    = pend_data[12:8];
    end

    if (bus_rd) checkOutput($sformatf("rd_reg%0d", sel), HRDATA, exp_rd);
    checkOutput("irq", {31'b0, IRQ}, {31'b0, irq_exp});
    pend_wr   = bus_wr;
    pend_reg  = sel;
    pend_data = wdata;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic push_byte(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic read_reg(input logic [1:0] sel);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, sel, 32'h0);
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [31:0] d);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, sel, d);
    idle();
  endtask

  task automatic apply_reset();
    HRESETN  = 1'b0;
    RX_VALID = 1'b0;
    HSEL     = 1'b0;
    HTRANS   = 2'b00;
    HWRITE   = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETN      = 1'b1;
    fifo_q.delete();
    model_ovf    = 1'b0;
    model_irq_en = 1'b0;
    model_thr    = 5'd1;
    pend_wr      = 1'b0;
    checkOutput("rst_hrdata", HRDATA, 32'h0);
    checkOutput("rst_irq", {31'b0, IRQ}, 32'h0);
    checkOutput("hreadyout", {31'b0, HREADYOUT}, 32'h1);
    checkOutput("hresp", {30'b0, HRESP}, 32'h0);
  endtask

  initial begin
    int r;
    int bias;
    RX_DATA = 8'h00;
    HADDR   = 4'h0;
    HSIZE   = 3'b010;
    HWDATA  = 32'h0;
    HREADY  = 1'b1;
    apply_reset();

    read_reg(2'd1);
    checkOutput("t1_status", HRDATA, 32'h0000_0000);
    read_reg(2'd2);
    checkOutput("t1_ctrl", HRDATA, 32'h0000_0100);

    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    for (int i = 0; i < 4; i++) begin
      read_reg(2'd0);
      checkOutput("t2_data", HRDATA, (i < 3) ? (32'h141 + 32'(i)) : 32'h0);
    end
    read_reg(2'd1);
    checkOutput("t2_status", HRDATA, 32'h0);

    for (int i = 0; i < 16; i++) push_byte(8'(i));
    push_byte(8'h55);
    read_reg(2'd1);
    checkOutput("t3_status", HRDATA, 32'h0000_1007);
    for (int i = 0; i < 17; i++) begin
      read_reg(2'd0);
      checkOutput("t3_data", HRDATA, (i < 16) ? (32'h100 + 32'(i)) : 32'h0);
    end
    write_reg(2'd3, 32'h1);

    write_reg(2'd2, 32'h401);
    for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i));
    idle();
    idle();
    checkOutput("t4_irq_low", {31'b0, IRQ}, 32'h0);
    push_byte(8'h63);
    idle();
    idle();
    checkOutput("t4_irq_high", {31'b0, IRQ}, 32'h1);
    read_reg(2'd0);
    idle();
    idle();
    checkOutput("t4_irq_drop", {31'b0, IRQ}, 32'h0);
    write_reg(2'd3, 32'h2);

    push_byte(8'h10);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 2'd0, 32'h0);
    checkOutput("t5_pop", HRDATA, 32'h110);
    read_reg(2'd1);
    checkOutput("t5_status", HRDATA, 32'h101);
    read_reg(2'd0);
    checkOutput("t5_new", HRDATA, 32'h177);

    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 32'h3);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 2'd0, 32'h0);
    read_reg(2'd1);
    checkOutput("t6_status", HRDATA, 32'h4);
    read_reg(2'd0);
    checkOutput("t6_data", HRDATA, 32'h0);
    write_reg(2'd3, 32'h1);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 32'h1F01);
    apply_reset();
    read_reg(2'd2);
    checkOutput("t7_ctrl", HRDATA, 32'h100);

    for (int i = 0; i < 3000; i++) begin
      bias = ((i / 250) % 2 == 1) ? 85 : 25;
      r = $urandom_range(0, 99);
      if (r < 35)      applyStimulus(($urandom % 100) < bias, 8'($urandom), 1'b1, 1'b0, 2'd0, 32'h0);
      else if (r < 48) applyStimulus(($urandom % 100) < bias, 8'($urandom), 1'b1, 1'b0, 2'd1, 32'h0);
      else if (r < 52) applyStimulus(($urandom % 100) < bias, 8'($urandom), 1'b1, 1'b0, 2'd2, 32'h0);
      else if (r < 54) applyStimulus(($urandom % 100) < bias, 8'($urandom), 1'b1, 1'b0, 2'd3, 32'h0);
      else if (r < 58) applyStimulus(($urandom % 100) < bias, 8'($urandom), 1'b0, 1'b1, 2'd2, $urandom);
      else if (r < 61) applyStimulus(($urandom % 100) < bias, 8'($urandom), 1'b0, 1'b1, 2'd3,
                                     {$urandom_range(0, 31), 1'b0, 1'($urandom)} == 0 ? 32'h0 :
                                     (($urandom % 8 == 0) ? 32'h3 : 32'h1));
      else             applyStimulus(($urandom % 100) < bias, 8'($urandom), 1'b0, 1'b0, 2'd0, 32'h0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
